// File: rtl/response_capture_pkg.sv
// response_capture_pkg: declarations shared by response_capture and capture_misr.
//   state_t    - controller states IDLE / COLLECT / DONE
//   NUM_VEC    - number of distinct 4-bit stimulus vectors
//   MISR_POLY  - x^16+x^12+x^5+1 feedback taps (implicit x^16 term)
//   MISR_SEED  - signature register start value
//   misr_step  - one MISR clock: shift, feed back, fold in a data word
package response_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int unsigned NUM_VEC   = 16;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  function automatic logic [15:0] misr_step(input logic [15:0] cur,
                                            input logic [15:0] din);
    return {cur[14:0], 1'b0} ^ (cur[15] ? MISR_POLY : 16'h0000) ^ din;
  endfunction

endpackage

// File: rtl/response_capture_misr.sv
// capture_misr: 16-bit multiple-input signature register.
//   clk, rst_n - rising-edge clock, synchronous active-low reset (clears to 0)
//   load       - load MISR_SEED (wins over shift)
//   shift      - fold data_in into the signature
//   data_in    - 16-bit word to fold
//   sig        - current signature
module capture_misr
  import response_capture_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        shift,
  input  logic [15:0] data_in,
  output logic [15:0] sig
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (load) begin
      sig <= MISR_SEED;
    end else if (shift) begin
      sig <= misr_step(sig, data_in);
    end
  end

endmodule

// File: rtl/response_capture.sv
// response_capture: records the response of a 4-input unit under test for each
// of the 16 stimulus vectors, tracks coverage and flags inconsistent responses.
//   clk, rst_n   - rising-edge clock, synchronous active-low reset
//   start        - pulse: clear everything and (re)enter COLLECT
//   in_valid/in_ready, in_vec, in_y - sample handshake, vector {a,b,c,d}, response
//   covered      - bit i set once vector i has been seen
//   done         - high in DONE
//   conflict, conflict_idx - sticky mismatch flag and index of the first one
//   sample_cnt   - accepted samples, saturating at 255
//   rd_idx/rd_data - combinational table read, 0 for uncovered entries
// Optional (macro RESPONSE_CAPTURE_SIGNATURE_EN):
//   sig, sig_valid - MISR signature of the table, valid 16 cycles after DONE entry
module response_capture
  import response_capture_pkg::*;
#(
  parameter int unsigned OUT_W            = 1,
  parameter int unsigned STOP_ON_CONFLICT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_vec,
  input  logic [OUT_W-1:0] in_y,
  output logic [15:0]      covered,
  output logic             done,
  output logic             conflict,
  output logic [3:0]       conflict_idx,
  output logic [7:0]       sample_cnt,
  input  logic [3:0]       rd_idx,
  output logic [OUT_W-1:0] rd_data
`ifdef RESPONSE_CAPTURE_SIGNATURE_EN
  ,
  output logic [15:0]      sig,
  output logic             sig_valid
`endif
);

  state_t           state_q;
  logic [OUT_W-1:0] resp_tbl [NUM_VEC];

  logic        accept;
  logic        hit;
  logic        mismatch;
  logic [15:0] covered_nxt;
  logic        stop_now;

  assign in_ready    = (state_q == COLLECT);
  assign done        = (state_q == DONE);
  assign accept      = in_ready && in_valid;
  assign hit         = covered[in_vec];
  assign mismatch    = hit && (resp_tbl[in_vec] != in_y);
  assign covered_nxt = covered | (16'(1) << in_vec);
  // Only the first conflict can stop collection; later ones just stay sticky.
  assign stop_now    = accept && ((covered_nxt == '1) ||
                       ((STOP_ON_CONFLICT != 0) && mismatch && !conflict));

  assign rd_data = covered[rd_idx] ? resp_tbl[rd_idx] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      covered      <= '0;
      conflict     <= 1'b0;
      conflict_idx <= '0;
      sample_cnt   <= '0;
    end else if (start) begin
      state_q      <= COLLECT;
      covered      <= '0;
      conflict     <= 1'b0;
      conflict_idx <= '0;
      sample_cnt   <= '0;
    end else if (accept) begin
      if (!hit) begin
        covered[in_vec] <= 1'b1;
      end else if (mismatch) begin
        conflict <= 1'b1;
        if (!conflict) conflict_idx <= in_vec;
      end
      if (sample_cnt != 8'hFF) sample_cnt <= sample_cnt + 8'd1;
      if (stop_now) state_q <= DONE;
    end
  end

  // A stored response is never overwritten; only the first sample of a vector writes.
  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      for (int unsigned i = 0; i < NUM_VEC; i++) resp_tbl[i] <= '0;
    end else if (accept && !hit) begin
      resp_tbl[in_vec] <= in_y;
    end
  end

`ifdef RESPONSE_CAPTURE_SIGNATURE_EN
  logic             enter_done;
  logic             fold_active;
  logic [3:0]       fold_ptr;
  logic [OUT_W-1:0] fold_entry;
  logic [15:0]      fold_word;

  assign enter_done = stop_now && !start;
  assign fold_entry = resp_tbl[fold_ptr];

  if (OUT_W >= 16) begin : g_trunc
    assign fold_word = fold_entry[15:0];
  end else begin : g_ext
    assign fold_word = {{(16 - OUT_W){1'b0}}, fold_entry};
  end

  // Seed loads on the DONE-entry edge; entries 0..15 fold on the next 16 edges.
  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      fold_active <= 1'b0;
      fold_ptr    <= '0;
      sig_valid   <= 1'b0;
    end else if (enter_done) begin
      fold_active <= 1'b1;
      fold_ptr    <= '0;
    end else if (fold_active) begin
      fold_ptr <= fold_ptr + 4'd1;
      if (fold_ptr == 4'hF) begin
        fold_active <= 1'b0;
        sig_valid   <= 1'b1;
      end
    end
  end

  capture_misr u_misr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (start || enter_done),
    .shift   (fold_active),
    .data_in (fold_word),
    .sig     (sig)
  );
`endif

endmodule

// File: tb/tb_response_capture.sv
module tb_response_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_vec = '0;
  logic [0:0]  in_y = '0;
  logic [15:0] covered;
  logic        done;
  logic        conflict;
  logic [3:0]  conflict_idx;
  logic [7:0]  sample_cnt;
  logic [3:0]  rd_idx = '0;
  logic [0:0]  rd_data;
`ifdef RESPONSE_CAPTURE_SIGNATURE_EN
  logic [15:0] sig;
  logic        sig_valid;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: what the table should hold after each clock edge.
  bit        m_tbl [16];
  bit [15:0] m_cov;
  int        m_cnt;
  bit        m_conf;
  int        m_cidx;
  int        m_state;  // 0 idle, 1 collecting, 2 finished

  response_capture #(.OUT_W(1), .STOP_ON_CONFLICT(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_vec       (in_vec),
    .in_y         (in_y),
    .covered      (covered),
    .done         (done),
    .conflict     (conflict),
    .conflict_idx (conflict_idx),
    .sample_cnt   (sample_cnt),
    .rd_idx       (rd_idx),
    .rd_data      (rd_data)
`ifdef RESPONSE_CAPTURE_SIGNATURE_EN
    ,
    .sig          (sig),
    .sig_valid    (sig_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    in_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic model_clear;
    for (int i = 0; i < 16; i++) m_tbl[i] = 1'b0;
    m_cov = '0; m_cnt = 0; m_conf = 1'b0; m_cidx = 0;
  endtask

  // Applies the pending inputs to the model as one clock edge would.
  task automatic model_edge;
    bit first;
    first = 1'b0;
    if (!rst_n) begin
      model_clear(); m_state = 0;
    end else if (start) begin
      model_clear(); m_state = 1;
    end else if (m_state == 1 && in_valid) begin
      if (!m_cov[in_vec]) begin
        m_tbl[in_vec] = in_y[0];
        m_cov[in_vec] = 1'b1;
      end else if (m_tbl[in_vec] != in_y[0]) begin
        if (!m_conf) begin m_cidx = in_vec; first = 1'b1; end
        m_conf = 1'b1;
      end
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      if (m_cov == 16'hFFFF || first) m_state = 2;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (covered !== 16'h0000) begin errors++; $display("FAIL reset_covered got %h exp 0000", covered); end
    checks++; if (sample_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", sample_cnt); end
    checks++; if (conflict !== 1'b0 || conflict_idx !== 4'd0) begin errors++; $display("FAIL reset_conflict got %b/%0d exp 0/0", conflict, conflict_idx); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready got %b exp 0", in_ready); end
  endtask

  task automatic test_full_sweep;
    int accepted;
    do_start();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready got %b exp 1", in_ready); end
    accepted = 0;
    while (accepted < 16) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_vec = 4'(accepted);
      in_y = 1'(accepted & 1);
      tick();
      if (in_valid) accepted++;
      in_valid = 1'b0;
      if (accepted < 16) begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL sweep_early_done after %0d samples", accepted); end
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sweep_done got %b exp 1", done); end
    checks++; if (covered !== 16'hFFFF) begin errors++; $display("FAIL sweep_covered got %h exp ffff", covered); end
    checks++; if (sample_cnt !== 8'd16) begin errors++; $display("FAIL sweep_cnt got %0d exp 16", sample_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sweep_ready_done got %b exp 0", in_ready); end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i); #1;
      checks++; if (rd_data !== 1'(i & 1)) begin errors++; $display("FAIL sweep_rd[%0d] got %b exp %0d", i, rd_data, i & 1); end
    end
  endtask

  task automatic test_conflict;
    do_start();
    in_valid = 1'b1; in_vec = 4'd3; in_y = 1'b1; tick();
    in_y = 1'b0; tick();
    in_valid = 1'b0;
    rd_idx = 4'd3; #1;
    checks++; if (conflict !== 1'b1) begin errors++; $display("FAIL conf_flag got %b exp 1", conflict); end
    checks++; if (conflict_idx !== 4'd3) begin errors++; $display("FAIL conf_idx got %0d exp 3", conflict_idx); end
    checks++; if (rd_data !== 1'b1) begin errors++; $display("FAIL conf_rd got %b exp 1", rd_data); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL conf_done got %b exp 1", done); end
    checks++; if (sample_cnt !== 8'd2) begin errors++; $display("FAIL conf_cnt got %0d exp 2", sample_cnt); end
    rd_idx = 4'd4; #1;
    checks++; if (rd_data !== 1'b0) begin errors++; $display("FAIL conf_rd_uncov got %b exp 0", rd_data); end
  endtask

  task automatic test_saturate;
    do_start();
    in_valid = 1'b1; in_vec = 4'd0; in_y = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    in_valid = 1'b0;
    checks++; if (sample_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt got %0d exp 255", sample_cnt); end
    checks++; if (covered !== 16'h0001) begin errors++; $display("FAIL sat_covered got %h exp 0001", covered); end
    checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL sat_conflict got %b exp 0", conflict); end
    checks++; if (done !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL sat_state got done=%b ready=%b exp 0/1", done, in_ready); end
  endtask

  task automatic test_restart;
    do_start();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin in_vec = 4'(i); in_y = 1'b1; tick(); end
    start = 1'b1; in_vec = 4'd9; tick();
    start = 1'b0; in_valid = 1'b0;
    checks++; if (covered !== 16'h0000) begin errors++; $display("FAIL restart_covered got %h exp 0000", covered); end
    checks++; if (sample_cnt !== 8'd0) begin errors++; $display("FAIL restart_cnt got %0d exp 0", sample_cnt); end
    checks++; if (in_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL restart_state got ready=%b done=%b exp 1/0", in_ready, done); end
  endtask

  task automatic test_reset_mid;
    do_start();
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin in_vec = 4'(i); in_y = 1'b1; tick(); end
    in_vec = 4'd7; rst_n = 1'b0; tick();
    in_valid = 1'b0;
    checks++; if (covered !== 16'h0000 || sample_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_data got cov=%h cnt=%0d exp 0/0", covered, sample_cnt); end
    checks++; if (in_ready !== 1'b0 || done !== 1'b0 || conflict !== 1'b0 || conflict_idx !== 4'd0) begin errors++; $display("FAIL rstmid_ctrl got ready=%b done=%b conf=%b idx=%0d exp 0", in_ready, done, conflict, conflict_idx); end
    rst_n = 1'b1; tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_idle got ready=%b exp 0", in_ready); end
  endtask

  task automatic test_random;
    model_clear(); m_state = 0;
    start = 1'b1; model_edge(); tick(); start = 1'b0;
    for (int c = 0; c < 600; c++) begin
      start    = ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_vec   = 4'($urandom_range(0, 15));
      in_y     = 1'($urandom_range(0, 15) == 0);
      model_edge();
      tick();
      start = 1'b0;
      rd_idx = 4'($urandom_range(0, 15)); #1;
      checks++; if (covered !== m_cov) begin errors++; $display("FAIL rand_covered cyc %0d got %h exp %h", c, covered, m_cov); end
      checks++; if (sample_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rand_cnt cyc %0d got %0d exp %0d", c, sample_cnt, m_cnt); end
      checks++; if (conflict !== m_conf || (m_conf && conflict_idx !== 4'(m_cidx))) begin errors++; $display("FAIL rand_conflict cyc %0d got %b/%0d exp %b/%0d", c, conflict, conflict_idx, m_conf, m_cidx); end
      checks++; if (done !== (m_state == 2) || in_ready !== (m_state == 1)) begin errors++; $display("FAIL rand_state cyc %0d got done=%b ready=%b exp state %0d", c, done, in_ready, m_state); end
      checks++; if (rd_data !== 1'(m_cov[rd_idx] & m_tbl[rd_idx])) begin errors++; $display("FAIL rand_rd[%0d] cyc %0d got %b exp %b", rd_idx, c, rd_data, m_tbl[rd_idx]); end
    end
    in_valid = 1'b0;
  endtask

`ifdef RESPONSE_CAPTURE_SIGNATURE_EN
  task automatic test_signature;
    logic [15:0] exp_sig;
    do_start();
    in_valid = 1'b1; in_y = 1'b0;
    for (int i = 0; i < 16; i++) begin in_vec = 4'(i); tick(); end
    in_valid = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sig_done got %b exp 1", done); end
    for (int i = 0; i < 15; i++) tick();
    checks++; if (sig_valid !== 1'b0) begin errors++; $display("FAIL sig_valid_early got %b exp 0", sig_valid); end
    tick();
    exp_sig = 16'hFFFF;
    for (int i = 0; i < 16; i++)
      exp_sig = ((exp_sig * 2) & 16'hFFFF) ^ ((exp_sig >= 16'h8000) ? 16'h1021 : 16'h0000);
    checks++; if (sig_valid !== 1'b1) begin errors++; $display("FAIL sig_valid got %b exp 1", sig_valid); end
    checks++; if (sig !== exp_sig) begin errors++; $display("FAIL sig_value got %h exp %h", sig, exp_sig); end
    tick(); tick();
    checks++; if (sig_valid !== 1'b1) begin errors++; $display("FAIL sig_valid_hold got %b exp 1", sig_valid); end
    do_start();
    checks++; if (sig_valid !== 1'b0) begin errors++; $display("FAIL sig_valid_clear got %b exp 0", sig_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_sweep();
    test_conflict();
    test_saturate();
    test_restart();
    test_reset_mid();
    test_random();
`ifdef RESPONSE_CAPTURE_SIGNATURE_EN
    test_signature();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/response_capture.md
RESPONSE_CAPTURE -- requirements
Module: response_capture

Interface
REQ-001 SHALL have parameter OUT_W, default 1: width of the observed response from the unit under test.
REQ-002 SHALL have parameter STOP_ON_CONFLICT, default 1: when 1, the first conflict ends collection.
REQ-003 SHALL have port clk, input, 1: single rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: single-cycle pulse that clears the table and begins collection.
REQ-006 SHALL have port in_valid, input, 1: a sample is present.
REQ-007 SHALL have port in_ready, output, 1: the block accepts a sample.
REQ-008 SHALL have port in_vec, input, 4: stimulus {a,b,c,d}, with a as the MSB.
REQ-009 SHALL have port in_y, input, OUT_W: response observed for in_vec.
REQ-010 SHALL have port covered, output, 16: bit i is set once vector i has been seen.
REQ-011 SHALL have port done, output, 1: the block is in the DONE state.
REQ-012 SHALL have port conflict, output, 1: sticky flag for the same vector returning a different response.
REQ-013 SHALL have port conflict_idx, output, 4: vector index of the first conflict.
REQ-014 SHALL have port sample_cnt, output, 8: count of accepted samples, saturating at 255.
REQ-015 SHALL have port rd_idx, input, 4: table read address.
REQ-016 SHALL have port rd_data, output, OUT_W: stored response for rd_idx, combinational read.

Function
REQ-017 SHALL implement states IDLE, COLLECT and DONE.
REQ-018 IDLE SHALL go to COLLECT on start; table, covered, conflict, conflict_idx and sample_cnt clear in the same edge.
REQ-019 in_ready SHALL be 1 only in COLLECT; a sample is accepted when in_valid and in_ready are both 1.
REQ-020 On accepting a sample for an uncovered index, the block SHALL store in_y, set covered[index] and increment sample_cnt, all visible the next cycle.
REQ-021 On accepting a sample for a covered index with an equal response, the block SHALL increment sample_cnt only.
REQ-022 On accepting a sample for a covered index with an unequal response, the block SHALL set conflict and, if conflict was 0, load conflict_idx; the stored value is not overwritten.
REQ-023 COLLECT SHALL go to DONE on the edge after the accepted sample that makes covered == 16'hFFFF, or after a first conflict when STOP_ON_CONFLICT=1.
REQ-024 start asserted in COLLECT or DONE SHALL restart: clear everything and enter COLLECT, and it takes priority over a simultaneous sample.
REQ-025 sample_cnt SHALL hold at 255 and never wrap.
REQ-026 rd_data SHALL read as 0 for uncovered entries.
REQ-027 done SHALL be 1 exactly when the state is DONE.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL enter IDLE, with in_ready, done and conflict at 0, and covered, conflict_idx, sample_cnt and the table all at 0.
REQ-029 Reset during COLLECT or during signature generation SHALL abandon the operation, and no partial result SHALL remain.

Configuration
REQ-030 When RESPONSE_CAPTURE_SIGNATURE_EN is defined, the block SHALL add outputs sig[15:0] and sig_valid.
REQ-031 On entry to DONE, the block SHALL fold table entries 0..15 in order, one per cycle, into a 16-bit MISR: polynomial x^16+x^12+x^5+1, seed 16'hFFFF, entry zero-extended or truncated to 16 bits.
REQ-032 sig_valid SHALL rise 16 cycles after DONE entry and hold until start or reset.
REQ-033 Without the macro, sig and sig_valid SHALL be absent and no MISR logic SHALL exist.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE, COLLECT, DONE), NUM_VEC=16, the MISR polynomial constant and the seed constant.
REQ-035 One sub-module, capture_misr (16-bit MISR with load and shift enables), SHALL be instantiated only under the macro.

Verification
REQ-036 Reset, then start, then vectors 0..15 with in_y=i[0] -> DONE on the edge after the 16th sample, covered=FFFF, sample_cnt=16, rd_data(5)=1.
REQ-037 Vector 3 sent with y=1, then vector 3 again with y=0 -> conflict=1, conflict_idx=3, rd_data(3)=1, DONE when STOP_ON_CONFLICT=1.
REQ-038 300 samples of vector 0 with the same y -> sample_cnt=255, covered=0001, no conflict, still in COLLECT.
REQ-039 start pulsed in the same cycle as an accepted sample mid-COLLECT -> covered=0, sample_cnt=0 next cycle.
REQ-040 rst_n=0 during the 8th sample -> all outputs 0, IDLE, in_ready=0.
REQ-041 With the macro defined and an all-zero table -> sig_valid 16 cycles after DONE, sig equal to the reference-model MISR of 16 zero words from seed FFFF.
